// File: rtl/axis_labcontrol_master.sv
// AXI4-Stream slave to LabControl bus master.
// Each accepted beat becomes one setup/strobe/hold write cycle on DIOA..DIOD.
module axis_labcontrol_master #(
  parameter int           AXIS_DATA_WIDTH = 16,
  parameter int           LC_DATA_WIDTH   = 16,
  parameter logic [7:0]   LC_ADDRESS      = 8'hFF,
  parameter logic [2:0]   LC_SUBBUS       = 3'd0,
  parameter bit           TWOS_COMPL      = 1'b1,
  parameter int           SETUP_CYCLES    = 4,
  parameter int           STROBE_CYCLES   = 8,
  parameter int           HOLD_CYCLES     = 4
) (
  input  logic                       s_axis_aclk,
  input  logic                       s_axis_areset,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  output logic [7:0]                 DIOA,
  output logic [7:0]                 DIOB,
  output logic [7:0]                 DIOC,
  output logic [7:0]                 DIOD,
  output logic                       lc_oe,
  output logic                       busy
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] STROBE_LD = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYCLES - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_tready;
  logic [7:0]  r_dioa;
  logic [7:0]  r_diob;
  logic [7:0]  r_dioc;
  logic [7:0]  r_diod;
  logic        r_oe;
  logic        r_busy;
  logic [15:0] w_word;

  // Fit the AXIS word onto the fixed 16-bit LabControl data bus
  generate
    if (AXIS_DATA_WIDTH >= LC_DATA_WIDTH) begin : g_trunc
      assign w_word = s_axis_tdata[LC_DATA_WIDTH-1:0];
    end else if (TWOS_COMPL) begin : g_sext
      assign w_word = {{(LC_DATA_WIDTH-AXIS_DATA_WIDTH)
                       {s_axis_tdata[AXIS_DATA_WIDTH-1]}},
                       s_axis_tdata};
    end else begin : g_zext
      assign w_word = {{(LC_DATA_WIDTH-AXIS_DATA_WIDTH){1'b0}},
                       s_axis_tdata};
    end
  endgenerate

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      r_state  <= IDLE;
      r_cnt    <= 8'd0;
      r_tready <= 1'b0;
      r_dioa   <= 8'd0;
      r_diob   <= 8'd0;
      r_dioc   <= 8'd0;
      r_diod   <= 8'd0;
      r_oe     <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (s_axis_tvalid && r_tready) begin
            r_state  <= SETUP;
            r_cnt    <= SETUP_LD;
            r_tready <= 1'b0;
            r_dioa   <= w_word[7:0];
            r_diob   <= w_word[15:8];
            r_dioc   <= LC_ADDRESS;
            r_diod   <= {3'b000, LC_SUBBUS, 1'b0, 1'b0};
            r_oe     <= 1'b1;
            r_busy   <= 1'b1;
          end else begin
            r_tready <= 1'b1;
          end
        end
        SETUP: begin
          if (r_cnt == 8'd0) begin
            r_state   <= STROBE;
            r_cnt     <= STROBE_LD;
            r_diod[0] <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        STROBE: begin
          if (r_cnt == 8'd0) begin
            r_state   <= HOLD;
            r_cnt     <= HOLD_LD;
            r_diod[0] <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        HOLD: begin
          if (r_cnt == 8'd0) begin
            r_state  <= IDLE;
            r_tready <= 1'b1;
            r_dioa   <= 8'd0;
            r_diob   <= 8'd0;
            r_dioc   <= 8'd0;
            r_diod   <= 8'd0;
            r_oe     <= 1'b0;
            r_busy   <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_axis_tready = r_tready;
  assign DIOA          = r_dioa;
  assign DIOB          = r_diob;
  assign DIOC          = r_dioc;
  assign DIOD          = r_diod;
  assign lc_oe         = r_oe;
  assign busy          = r_busy;

endmodule

// File: tb/tb_axis_labcontrol_master.sv
// Directed bench for axis_labcontrol_master.
// Several parameterisations share one clock and reset.
module tb_axis_labcontrol_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // defaults
  logic [15:0] td0 = '0;
  logic        tv0 = 1'b0;
  logic        rdy0, oe0, bz0;
  logic [7:0]  a0, b0, c0, dd0;
  // 12-bit sign extend
  logic [11:0] td12 = '0;
  logic        tv12 = 1'b0;
  logic        rdy1, oe1, bz1;
  logic [7:0]  a1, b1, c1, dd1;
  // 12-bit zero extend
  logic        rdy2, oe2, bz2;
  logic [7:0]  a2, b2, c2, dd2;
  // 20-bit truncate
  logic [19:0] td20 = '0;
  logic        rdy3, oe3, bz3;
  logic [7:0]  a3, b3, c3, dd3;
  // minimal 1/1/1 timing
  logic [15:0] td4 = '0;
  logic        tv4 = 1'b0;
  logic        rdy4, oe4, bz4;
  logic [7:0]  a4, b4, c4, dd4;

  axis_labcontrol_master u0 (
    .s_axis_aclk(clk), .s_axis_areset(rst),
    .s_axis_tdata(td0), .s_axis_tvalid(tv0),
    .s_axis_tready(rdy0),
    .DIOA(a0), .DIOB(b0), .DIOC(c0), .DIOD(dd0),
    .lc_oe(oe0), .busy(bz0)
  );

  axis_labcontrol_master #(
    .AXIS_DATA_WIDTH(12), .TWOS_COMPL(1'b1)
  ) u1 (
    .s_axis_aclk(clk), .s_axis_areset(rst),
    .s_axis_tdata(td12), .s_axis_tvalid(tv12),
    .s_axis_tready(rdy1),
    .DIOA(a1), .DIOB(b1), .DIOC(c1), .DIOD(dd1),
    .lc_oe(oe1), .busy(bz1)
  );

  axis_labcontrol_master #(
    .AXIS_DATA_WIDTH(12), .TWOS_COMPL(1'b0)
  ) u2 (
    .s_axis_aclk(clk), .s_axis_areset(rst),
    .s_axis_tdata(td12), .s_axis_tvalid(tv12),
    .s_axis_tready(rdy2),
    .DIOA(a2), .DIOB(b2), .DIOC(c2), .DIOD(dd2),
    .lc_oe(oe2), .busy(bz2)
  );

  axis_labcontrol_master #(
    .AXIS_DATA_WIDTH(20)
  ) u3 (
    .s_axis_aclk(clk), .s_axis_areset(rst),
    .s_axis_tdata(td20), .s_axis_tvalid(tv12),
    .s_axis_tready(rdy3),
    .DIOA(a3), .DIOB(b3), .DIOC(c3), .DIOD(dd3),
    .lc_oe(oe3), .busy(bz3)
  );

  axis_labcontrol_master #(
    .SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1)
  ) u4 (
    .s_axis_aclk(clk), .s_axis_areset(rst),
    .s_axis_tdata(td4), .s_axis_tvalid(tv4),
    .s_axis_tready(rdy4),
    .DIOA(a4), .DIOB(b4), .DIOC(c4), .DIOD(dd4),
    .lc_oe(oe4), .busy(bz4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [34:0] got;
    #1;
    got = {a0, b0, c0, dd0, oe0, bz0, rdy0};
    checks++;
    if (got !== 35'd0) begin
      errors++;
      $display("FAIL reset_outs got=%h want=0", got);
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    tick();
    checks++;
    if ({rdy0, rdy4, bz0, oe0} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_release got=%b want=1100",
               {rdy0, rdy4, bz0, oe0});
    end
  endtask

  task automatic test_single();
    logic [36:0] got, exp;
    logic        act;
    td0 = 16'h1234;
    tv0 = 1'b1;
    tick();
    tv0 = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      if (c > 1) tick();
      act = (c <= 16);
      exp = {act ? 8'h34 : 8'h00,
             act ? 8'h12 : 8'h00,
             act ? 8'hFF : 8'h00,
             7'd0, (c >= 5 && c <= 12),
             act, act, (c == 17)};
      got = {a0, b0, c0, dd0, oe0, bz0, rdy0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL single_cyc%0d got=%h want=%h", c, got, exp);
      end
    end
  endtask

  task automatic test_hold_off();
    int          acc[3];
    logic [15:0] sdat[3];
    int          nacc = 0;
    int          nstb = 0;
    logic        prev = 1'b0;
    logic        hs;
    td0 = 16'h0001;
    tv0 = 1'b1;
    for (int n = 0; n < 60; n++) begin
      hs = tv0 && rdy0;
      tick();
      if (hs) begin
        if (nacc < 3) acc[nacc] = n;
        nacc++;
        if (nacc >= 3) tv0 = 1'b0;
        else td0 = 16'(nacc + 1);
      end
      if (dd0[0] && !prev) begin
        if (nstb < 3) sdat[nstb] = {b0, a0};
        nstb++;
      end
      prev = dd0[0];
    end
    tv0 = 1'b0;
    checks++;
    if (nacc !== 3) begin
      errors++;
      $display("FAIL holdoff_accepts got=%0d want=3", nacc);
    end
    checks++;
    if (nstb !== 3) begin
      errors++;
      $display("FAIL holdoff_strobes got=%0d want=3", nstb);
    end
    for (int i = 0; i < 3; i++) begin
      if (i < nacc) begin
        checks++;
        if (acc[i] !== 17 * i) begin
          errors++;
          $display("FAIL holdoff_acc%0d got=%0d want=%0d",
                   i, acc[i], 17 * i);
        end
      end
      if (i < nstb) begin
        checks++;
        if (sdat[i] !== 16'(i + 1)) begin
          errors++;
          $display("FAIL holdoff_data%0d got=%h want=%h",
                   i, sdat[i], 16'(i + 1));
        end
      end
    end
  endtask

  task automatic test_width();
    td12 = 12'h800;
    td20 = 20'hABCDE;
    tv12 = 1'b1;
    tick();
    tv12 = 1'b0;
    checks++;
    if ({b1, a1, c1} !== 24'hF800FF) begin
      errors++;
      $display("FAIL width_sext got=%h want=F800FF", {b1, a1, c1});
    end
    checks++;
    if ({b2, a2} !== 16'h0800) begin
      errors++;
      $display("FAIL width_zext got=%h want=0800", {b2, a2});
    end
    checks++;
    if ({b3, a3} !== 16'hBCDE) begin
      errors++;
      $display("FAIL width_trunc got=%h want=BCDE", {b3, a3});
    end
    repeat (20) tick();
    checks++;
    if ({rdy1, rdy2, rdy3} !== 3'b111) begin
      errors++;
      $display("FAIL width_idle got=%b want=111", {rdy1, rdy2, rdy3});
    end
  endtask

  task automatic test_reset_mid();
    int highs = 0;
    td0 = 16'h1234;
    tv0 = 1'b1;
    tick();
    tv0 = 1'b0;
    repeat (6) tick();
    checks++;
    if ({dd0[0], oe0} !== 2'b11) begin
      errors++;
      $display("FAIL rstmid_strobe got=%b want=11", {dd0[0], oe0});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({dd0[0], oe0, rdy0, bz0} !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_async got=%b want=0000",
               {dd0[0], oe0, rdy0, bz0});
    end
    @(posedge clk);
    #2 rst = 1'b0;
    tick();
    checks++;
    if (rdy0 !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_ready got=%b want=1", rdy0);
    end
    for (int n = 0; n < 30; n++) begin
      tick();
      if (dd0[0] || oe0) highs++;
    end
    checks++;
    if (highs !== 0) begin
      errors++;
      $display("FAIL rstmid_nostrobe got=%0d want=0", highs);
    end
  endtask

  task automatic test_min_timing();
    logic [10:0] exp[4];
    logic [10:0] got;
    exp[0] = {8'hFF, 1'b0, 1'b1, 1'b0};
    exp[1] = {8'hFF, 1'b1, 1'b1, 1'b0};
    exp[2] = {8'hFF, 1'b0, 1'b1, 1'b0};
    exp[3] = {8'h00, 1'b0, 1'b0, 1'b1};
    td4 = 16'h00FF;
    tv4 = 1'b1;
    tick();
    tv4 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick();
      got = {a4, dd4[0], oe4, rdy4};
      checks++;
      if (got !== exp[c]) begin
        errors++;
        $display("FAIL min_cyc%0d got=%h want=%h", c + 1, got, exp[c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int   acc[2];
    int   nacc = 0;
    int   nstb = 0;
    logic prev = 1'b0;
    logic hs;
    td4 = 16'h0001;
    tv4 = 1'b1;
    for (int n = 0; n < 14; n++) begin
      hs = tv4 && rdy4;
      tick();
      if (hs) begin
        if (nacc < 2) acc[nacc] = n;
        nacc++;
        if (nacc >= 2) tv4 = 1'b0;
        else td4 = 16'h0002;
      end
      if (dd4[0] && !prev) nstb++;
      prev = dd4[0];
    end
    tv4 = 1'b0;
    checks++;
    if (nacc !== 2 || nstb !== 2) begin
      errors++;
      $display("FAIL b2b_counts got=%0d/%0d want=2/2", nacc, nstb);
    end
    if (nacc >= 2) begin
      checks++;
      if (acc[1] - acc[0] !== 4) begin
        errors++;
        $display("FAIL b2b_period got=%0d want=4", acc[1] - acc[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_hold_off();
    test_width();
    test_reset_mid();
    test_min_timing();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
